// File: rtl/lock_input_conditioner.sv
// Front-end conditioner for the lock controller: 2-flop sync, per-bit debounce,
// and one-hot button pulses stretched for the slow-clock domain.
module lock_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned STRETCH_CYCLES  = 60000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic       lock_raw,
  input  logic       latch_raw,
  input  logic [3:0] switch_raw,
  output logic [3:0] btn_out,
  output logic       lock_lvl,
  output logic       latch_lvl,
  output logic [3:0] switch_out,
  output logic       multi_press
);

  localparam int unsigned NBITS = 10;
  localparam logic [CNT_W-1:0] DEB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES);

  // Bit map: [3:0] buttons, [4] lock, [5] latch, [9:6] code switches
  logic [NBITS-1:0] raw_vec;
  logic [NBITS-1:0] sync1_q, sync2_q;
  logic [NBITS-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] db_cnt_q [NBITS];
  logic [CNT_W-1:0] db_cnt_d [NBITS];

  logic [3:0]       prev_btn_q;
  logic [3:0]       cur_btn;
  logic [3:0]       btn_out_q, btn_out_d;
  logic [CNT_W-1:0] stretch_q, stretch_d;
  logic             multi_q, multi_d;
  logic             cur_onehot, cur_multi, btn_added;

  assign raw_vec = {switch_raw, latch_raw, lock_raw, btn_raw};

  // Debounce: a bit must disagree with its stable value DEBOUNCE_CYCLES in a row
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NBITS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DEB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign cur_btn    = stable_q[3:0];
  assign cur_onehot = (cur_btn != 4'd0) && ((cur_btn & (cur_btn - 4'd1)) == 4'd0);
  assign cur_multi  = (cur_btn != 4'd0) && !cur_onehot;
  assign btn_added  = |(cur_btn & ~prev_btn_q);

  // Press detection, chord rejection and pulse stretching
  always_comb begin
    btn_out_d = btn_out_q;
    stretch_d = stretch_q;
    multi_d   = multi_q;
    if (stretch_q != '0) begin
      stretch_d = stretch_q - CNT_W'(1);
      if (stretch_q == CNT_W'(1)) begin
        btn_out_d = 4'd0;
      end
    end
    if (prev_btn_q == 4'd0) begin
      if (cur_onehot) begin
        btn_out_d = cur_btn;
        stretch_d = STRETCH_LOAD;
      end else if (cur_multi) begin
        multi_d = 1'b1;
      end
    end else if (btn_added) begin
      multi_d = 1'b1;
    end
    // A chord is only forgiven once every button is released
    if (cur_btn == 4'd0) begin
      multi_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      prev_btn_q <= '0;
      btn_out_q  <= '0;
      stretch_q  <= '0;
      multi_q    <= 1'b0;
      for (int i = 0; i < NBITS; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= raw_vec;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      prev_btn_q <= cur_btn;
      btn_out_q  <= btn_out_d;
      stretch_q  <= stretch_d;
      multi_q    <= multi_d;
      for (int i = 0; i < NBITS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign btn_out     = btn_out_q;
  assign lock_lvl    = stable_q[4];
  assign latch_lvl   = stable_q[5];
  assign switch_out  = stable_q[9:6];
  assign multi_press = multi_q;

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Directed bench for lock_input_conditioner with short debounce/stretch settings.
module tb_lock_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a_btn_raw, a_switch_raw, a_btn_out, a_switch_out;
  logic       a_lock_raw, a_latch_raw, a_lock_lvl, a_latch_lvl, a_multi;
  logic [3:0] b_btn_raw, b_switch_raw, b_btn_out, b_switch_out;
  logic       b_lock_raw, b_latch_raw, b_lock_lvl, b_latch_lvl, b_multi;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lock_input_conditioner #(.DEBOUNCE_CYCLES(4), .STRETCH_CYCLES(8), .CNT_W(20)) u_dut_a (
    .clk(clk), .rst(rst), .btn_raw(a_btn_raw), .lock_raw(a_lock_raw),
    .latch_raw(a_latch_raw), .switch_raw(a_switch_raw), .btn_out(a_btn_out),
    .lock_lvl(a_lock_lvl), .latch_lvl(a_latch_lvl), .switch_out(a_switch_out),
    .multi_press(a_multi)
  );

  lock_input_conditioner #(.DEBOUNCE_CYCLES(4), .STRETCH_CYCLES(20), .CNT_W(20)) u_dut_b (
    .clk(clk), .rst(rst), .btn_raw(b_btn_raw), .lock_raw(b_lock_raw),
    .latch_raw(b_latch_raw), .switch_raw(b_switch_raw), .btn_out(b_btn_out),
    .lock_lvl(b_lock_lvl), .latch_lvl(b_latch_lvl), .switch_out(b_switch_out),
    .multi_press(b_multi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_btn_raw = 4'd0; a_switch_raw = 4'd0; a_lock_raw = 1'b0; a_latch_raw = 1'b0;
    b_btn_raw = 4'd0; b_switch_raw = 4'd0; b_lock_raw = 1'b0; b_latch_raw = 1'b0;
    tick();
    tick();
    n_cmp++; if (a_btn_out !== 4'd0) begin n_err++; $display("FAIL reset_btn got %b want 0000", a_btn_out); end
    n_cmp++; if (a_multi !== 1'b0) begin n_err++; $display("FAIL reset_multi got %b want 0", a_multi); end
    n_cmp++; if ({a_lock_lvl, a_latch_lvl} !== 2'b00) begin n_err++; $display("FAIL reset_levels got %b want 00", {a_lock_lvl, a_latch_lvl}); end
    n_cmp++; if (a_switch_out !== 4'd0) begin n_err++; $display("FAIL reset_switch got %b want 0000", a_switch_out); end
    n_cmp++; if ({b_btn_out, b_multi} !== 5'd0) begin n_err++; $display("FAIL reset_b got %b want 00000", {b_btn_out, b_multi}); end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if ({a_btn_out, a_multi, a_switch_out} !== 9'd0) begin n_err++; $display("FAIL idle k=%0d got %b want 0", k, {a_btn_out, a_multi, a_switch_out}); end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp;
    a_btn_raw = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = (k >= 7 && k <= 14) ? 4'b0010 : 4'b0000;
      n_cmp++; if (a_btn_out !== exp) begin n_err++; $display("FAIL clean_btn k=%0d got %b want %b", k, a_btn_out, exp); end
      n_cmp++; if (a_multi !== 1'b0) begin n_err++; $display("FAIL clean_multi k=%0d got %b want 0", k, a_multi); end
    end
    a_btn_raw = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_cmp++; if (a_btn_out !== 4'd0) begin n_err++; $display("FAIL release_btn k=%0d got %b want 0000", k, a_btn_out); end
    end
  endtask

  task automatic test_bounce();
    logic expl;
    for (int k = 0; k < 20; k++) begin
      a_btn_raw = ((k % 4) < 2) ? 4'b0001 : 4'b0000;
      tick();
      n_cmp++; if (a_btn_out !== 4'd0) begin n_err++; $display("FAIL bounce_btn k=%0d got %b want 0000", k, a_btn_out); end
    end
    a_btn_raw = 4'd0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++; if ({a_btn_out, a_multi} !== 5'd0) begin n_err++; $display("FAIL bounce_settle k=%0d got %b want 00000", k, {a_btn_out, a_multi}); end
    end
    for (int k = 0; k < 20; k++) begin
      a_lock_raw = ((k % 4) < 2);
      tick();
      n_cmp++; if (a_lock_lvl !== 1'b0) begin n_err++; $display("FAIL bounce_lock k=%0d got %b want 0", k, a_lock_lvl); end
    end
    a_lock_raw = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    // 3-cycle glitch is rejected
    a_lock_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_cmp++; if (a_lock_lvl !== 1'b0) begin n_err++; $display("FAIL glitch3_lock k=%0d got %b want 0", k, a_lock_lvl); end
      if (k == 3) a_lock_raw = 1'b0;
    end
    // 4-cycle pulse is just long enough to pass, and its fall likewise
    a_lock_raw = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      expl = (k >= 6 && k <= 9);
      n_cmp++; if (a_lock_lvl !== expl) begin n_err++; $display("FAIL pulse4_lock k=%0d got %b want %b", k, a_lock_lvl, expl); end
      if (k == 4) a_lock_raw = 1'b0;
    end
  endtask

  task automatic test_chord();
    logic [3:0] exp;
    logic       expm;
    a_btn_raw = 4'b1000;
    for (int k = 1; k <= 50; k++) begin
      tick();
      exp  = (k >= 7 && k <= 14) ? 4'b1000 : 4'b0000;
      expm = (k >= 10 && k <= 39);
      n_cmp++; if (a_btn_out !== exp) begin n_err++; $display("FAIL chord_btn k=%0d got %b want %b", k, a_btn_out, exp); end
      n_cmp++; if (a_multi !== expm) begin n_err++; $display("FAIL chord_multi k=%0d got %b want %b", k, a_multi, expm); end
      if (k == 3) a_btn_raw = 4'b1100;
      if (k == 33) a_btn_raw = 4'b0000;
    end
  endtask

  task automatic test_simultaneous();
    logic expm;
    a_btn_raw = 4'b0011;
    for (int k = 1; k <= 24; k++) begin
      tick();
      expm = (k >= 7 && k <= 16);
      n_cmp++; if (a_btn_out !== 4'd0) begin n_err++; $display("FAIL simul_btn k=%0d got %b want 0000", k, a_btn_out); end
      n_cmp++; if (a_multi !== expm) begin n_err++; $display("FAIL simul_multi k=%0d got %b want %b", k, a_multi, expm); end
      if (k == 10) a_btn_raw = 4'b0000;
    end
  endtask

  task automatic test_switch_latch();
    logic [3:0] exps;
    logic       expl;
    a_switch_raw = 4'b0011;
    a_latch_raw  = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exps = (k >= 6) ? 4'b0011 : 4'b0000;
      expl = (k >= 6 && k <= 25);
      n_cmp++; if (a_switch_out !== exps) begin n_err++; $display("FAIL switch k=%0d got %b want %b", k, a_switch_out, exps); end
      n_cmp++; if (a_latch_lvl !== expl) begin n_err++; $display("FAIL latch k=%0d got %b want %b", k, a_latch_lvl, expl); end
      n_cmp++; if (a_lock_lvl !== 1'b0) begin n_err++; $display("FAIL sw_lock k=%0d got %b want 0", k, a_lock_lvl); end
      if (k == 20) a_latch_raw = 1'b0;
    end
    a_switch_raw = 4'b0000;
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_reset_mid_stretch();
    logic [3:0] exp;
    a_btn_raw = 4'b0100;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp = (k >= 7) ? 4'b0100 : 4'b0000;
      n_cmp++; if (a_btn_out !== exp) begin n_err++; $display("FAIL prerst_btn k=%0d got %b want %b", k, a_btn_out, exp); end
    end
    rst = 1'b1;
    tick();
    n_cmp++; if ({a_btn_out, a_multi, a_lock_lvl, a_latch_lvl, a_switch_out} !== 11'd0) begin
      n_err++; $display("FAIL midrst_all got %b want 0", {a_btn_out, a_multi, a_lock_lvl, a_latch_lvl, a_switch_out});
    end
    rst = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      exp = (j >= 7 && j <= 14) ? 4'b0100 : 4'b0000;
      n_cmp++; if (a_btn_out !== exp) begin n_err++; $display("FAIL refire_btn j=%0d got %b want %b", j, a_btn_out, exp); end
    end
    a_btn_raw = 4'b0000;
    for (int k = 0; k < 12; k++) tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    b_btn_raw = 4'b0001;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k >= 7 && k <= 18)       exp = 4'b0001;
      else if (k >= 19 && k <= 38) exp = 4'b0010;
      else                         exp = 4'b0000;
      n_cmp++; if (b_btn_out !== exp) begin n_err++; $display("FAIL restart_btn k=%0d got %b want %b", k, b_btn_out, exp); end
      n_cmp++; if (b_multi !== 1'b0) begin n_err++; $display("FAIL restart_multi k=%0d got %b want 0", k, b_multi); end
      if (k == 8)  b_btn_raw = 4'b0000;
      if (k == 12) b_btn_raw = 4'b0010;
      if (k == 30) b_btn_raw = 4'b0000;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_chord();
    test_simultaneous();
    test_switch_latch();
    test_reset_mid_stretch();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lock_input_conditioner.md
Name: lock_input_conditioner

Overview:
- Upstream front end for the electronic lock controller. Sits between the raw board pins (4 push buttons, lock switch, latch switch, 4 code switches) and the lock FSM.
- Synchronises and debounces every input.
- Turns each button press into a one-hot pulse, stretched so the lock's ~1 kHz slow-clock domain is guaranteed to sample it.
- Rejects simultaneous multi-button presses.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles a synchronised input must differ from its stable value before the change is accepted (10 ms at 50 MHz).
- STRETCH_CYCLES, 60000: clk cycles a one-hot button pulse is held. Must exceed one slow-clock period (~50002 cycles).
- CNT_W, 20: width of the debounce and stretch counters. Must hold max(DEBOUNCE_CYCLES, STRETCH_CYCLES).

Ports:
- clk  input  1  system clock, one clock domain
- rst  input  1  synchronous, active-high reset
- btn_raw  input  4  raw push buttons, asynchronous, bouncy
- lock_raw  input  1  raw lock slide switch
- latch_raw  input  1  raw latch slide switch
- switch_raw  input  4  raw code-digit switches
- btn_out  output  4  stretched one-hot press pulse (8/4/2/1) or 0
- lock_lvl  output  1  debounced lock level
- latch_lvl  output  1  debounced latch level
- switch_out  output  4  debounced code switches
- multi_press  output  1  high while an illegal multi-button chord is held

Behaviour:
- Reset (rst high at a clk edge):
  - All sync flops, stable values, debounce counters and the stretch counter go to 0.
  - btn_out=0, lock_lvl=0, latch_lvl=0, switch_out=0, multi_press=0 on the following cycle.
  - Reset mid-stretch aborts the pulse immediately.
- Synchroniser: each of the 10 raw bits passes through 2 flops. This contributes 2 cycles of latency.
- Debounce, independent per bit:
  - If sync==stable, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable<=sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
  - Total latency from raw edge to stable output is DEBOUNCE_CYCLES+2 cycles.
- lock_lvl, latch_lvl and switch_out are the stable values, registered, with no further processing.
- Button event detection: compare the debounced button vector prev (last cycle) with cur.
  - prev==0 and cur one-hot: load btn_out=cur and stretch counter=STRETCH_CYCLES.
  - prev==0 and cur has 2 or more bits set (bits stabilised in the same cycle): multi_press=1, no pulse.
  - prev!=0 and cur has a bit not in prev (second button added while one held): multi_press=1, no new pulse. An in-progress stretch continues to completion.
  - multi_press clears only on the cycle cur becomes 0.
  - Releases never generate pulses.
- Stretch:
  - While the counter is non-zero it decrements each cycle and btn_out holds.
  - When it reaches 0, btn_out=0.
  - btn_out is therefore non-zero for exactly STRETCH_CYCLES cycles.
  - A valid new press while stretching (only possible when STRETCH_CYCLES > DEBOUNCE_CYCLES) reloads the counter and replaces btn_out with the new value.
- btn_out is always 0 or exactly one-hot. Two bits are never set.
- Counters saturate-free: both count within parameter range only, with no wrap.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8.)
- Clean press: btn_raw=0010 held for 20 cycles from a 0000 start -> btn_out=0010 first appears 6-7 cycles after the raw edge, stays exactly 8 cycles, then 0000. multi_press stays 0.
- Bounce rejection: btn_raw toggles 0001/0000 every 2 cycles for 20 cycles, then settles at 0 -> btn_out stays 0000 throughout. Repeat on lock_raw -> lock_lvl stays 0.
- Chord: btn_raw=1000 then 1100 3 cycles later, both held 30 cycles -> single 8-cycle pulse of 1000. multi_press=1 from 1100's debounce until both are released and debounced, then 0. No 0100 pulse.
- Switch/latch path: switch_raw=0011, latch_raw=1 then 0 after 20 cycles -> switch_out=0011 and latch_lvl=1 after 6 cycles; latch_lvl=0 six cycles after the fall.
- Reset mid-stretch: trigger a 0100 pulse, assert rst on stretch cycle 3 -> next cycle all outputs are 0. After rst drops with btn_raw still 0100, pulse re-fires after full debounce latency.
- Restart stretch: with STRETCH_CYCLES=20, press 0001, release, press 0010 within the stretch window -> btn_out switches to 0010 and holds 20 cycles from the second press's debounce.
